// File: rtl/decode_buffer_if.sv
// decode_buffer_if: fetch-side and dispatch-side bundle for decode_buffer.
//   in_valid/in_inst/in_pc/in_ready : fetch group, lane 0 oldest
//   out_valid/out_inst/out_pc/out_fu_class/out_illegal : oldest entries, lane 0 oldest
//   out_accept : number of presented entries dispatch takes this cycle
// slave  = the buffer, master = the fetch/dispatch environment.
interface decode_buffer_if #(
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2
);
  logic [IN_WIDTH-1:0]                  in_valid;
  logic [IN_WIDTH-1:0][31:0]            in_inst;
  logic [IN_WIDTH-1:0][31:0]            in_pc;
  logic                                 in_ready;
  logic [OUT_WIDTH-1:0]                 out_valid;
  logic [OUT_WIDTH-1:0][31:0]           out_inst;
  logic [OUT_WIDTH-1:0][31:0]           out_pc;
  logic [OUT_WIDTH-1:0][2:0]            out_fu_class;
  logic [OUT_WIDTH-1:0]                 out_illegal;
  logic [$clog2(OUT_WIDTH+1)-1:0]       out_accept;

  modport master (
    output in_valid, in_inst, in_pc, out_accept,
    input  in_ready, out_valid, out_inst, out_pc, out_fu_class, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_accept,
    output in_ready, out_valid, out_inst, out_pc, out_fu_class, out_illegal
  );
endinterface

// File: rtl/decode_buffer.sv
// decode_buffer: multi-lane RV32 decode stage feeding an in-order circular
// buffer between fetch and dispatch.
//   clock, reset     : single clock, synchronous active-high reset
//   flush            : drop every buffered entry next cycle
//   bus (slave)      : fetch group in, oldest OUT_WIDTH entries out
//   count            : occupancy
//   illegal_seen     : sticky, an illegal entry has been dequeued
//
// decode_lane: classifies one instruction into a functional-unit class
//   (0 illegal, 1 ALU, 2 MULT, 3 LSU/LUI, 4 control/system).

module decode_lane (
  input  logic [31:0] inst,
  output logic [2:0]  cls,
  output logic        ill
);
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    cls = 3'd0;
    case (opc)
      7'b0010011: begin // OP-IMM; shift forms constrain funct7
        if (f3 == 3'b001)      cls = (f7 == 7'h00) ? 3'd1 : 3'd0;
        else if (f3 == 3'b101) cls = (f7 == 7'h00 || f7 == 7'h20) ? 3'd1 : 3'd0;
        else                   cls = 3'd1;
      end
      7'b0110011: begin // OP; M-extension divides stay illegal
        if (f7 == 7'h00)                                     cls = 3'd1;
        else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) cls = 3'd1;
        else if (f7 == 7'h01 && !f3[2])                      cls = 3'd2;
      end
      7'b0110111: cls = 3'd3;                                          // LUI
      7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) cls = 3'd3; // loads
      7'b0100011: if (!f3[2] && f3 != 3'b011) cls = 3'd3;              // stores
      7'b0010111,
      7'b1101111: cls = 3'd4;                                          // AUIPC, JAL
      7'b1100111: if (f3 == 3'b000) cls = 3'd4;                        // JALR
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) cls = 3'd4;        // branches
      7'b1110011: if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011 ||
                      inst == 32'h1050_0073) cls = 3'd4;               // CSRRW/S/C, WFI
      default:    cls = 3'd0;
    endcase
  end

  assign ill = (cls == 3'd0);
endmodule

module decode_buffer #(
  parameter int IN_WIDTH        = 2,
  parameter int OUT_WIDTH       = 2,
  parameter int DEPTH           = 8,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  decode_buffer_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       illegal_seen
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int KW = $clog2(IN_WIDTH+1);
  localparam int AW = $clog2(OUT_WIDTH+1);
  // Largest occupancy that still leaves room for a whole fetch group.
  localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - IN_WIDTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  cls;
    logic        ill;
  } entry_t;

  entry_t                 mem [DEPTH];
  logic [PW-1:0]          head, tail;
  logic [CW-1:0]          cnt;
  entry_t [IN_WIDTH-1:0]  new_e;
  entry_t [OUT_WIDTH-1:0] pres;
  logic [KW-1:0]          k, k_acc;
  logic                   k_run;
  logic [AW-1:0]          nvalid, deq;
  logic                   halt, ill_deq, in_rdy;

  for (genvar g = 0; g < IN_WIDTH; g++) begin : g_dec
    logic [2:0] cls;
    logic       ill;
    decode_lane u_dec (.inst(bus.in_inst[g]), .cls(cls), .ill(ill));
    assign new_e[g] = '{inst: bus.in_inst[g], pc: bus.in_pc[g], cls: cls, ill: ill};
  end

  // Only the leading run of valid lanes is taken; anything after a gap drops.
  always_comb begin
    k     = '0;
    k_run = 1'b1;
    for (int i = 0; i < IN_WIDTH; i++) begin
      k_run = k_run & bus.in_valid[i];
      if (k_run) k = k + KW'(1);
    end
  end

  // Ready looks only at registered occupancy, never at this cycle's dequeue.
  assign in_rdy       = (cnt <= RDY_MAX);
  assign bus.in_ready = in_rdy;
  assign k_acc        = in_rdy ? k : '0;

  always_comb begin
    for (int i = 0; i < OUT_WIDTH; i++) pres[i] = mem[head + PW'(i)];
  end

  // Present the oldest entries; with halting enabled everything younger than
  // the first illegal lane is hidden so dispatch stops at it.
  always_comb begin
    halt   = 1'b0;
    nvalid = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      bus.out_valid[i]    = (CW'(i) < cnt) && !halt;
      bus.out_inst[i]     = pres[i].inst;
      bus.out_pc[i]       = pres[i].pc;
      bus.out_fu_class[i] = pres[i].cls;
      bus.out_illegal[i]  = pres[i].ill;
      if (bus.out_valid[i]) nvalid = nvalid + AW'(1);
      if (bus.out_valid[i] && pres[i].ill && HALT_ON_ILLEGAL != 0) halt = 1'b1;
    end
  end

  assign deq = (bus.out_accept < nvalid) ? bus.out_accept : nvalid;

  always_comb begin
    ill_deq = 1'b0;
    for (int i = 0; i < OUT_WIDTH; i++)
      if (AW'(i) < deq && pres[i].ill) ill_deq = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      illegal_seen <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(deq);
      tail <= tail + PW'(k_acc);
      cnt  <= cnt + CW'(k_acc) - CW'(deq);
      if (ill_deq) illegal_seen <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clock) begin
    if (!reset && !flush)
      for (int i = 0; i < IN_WIDTH; i++)
        if (KW'(i) < k_acc) mem[tail + PW'(i)] <= new_e[i];
  end

  assign count = cnt;
endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;
  localparam int IW    = 2;
  localparam int OW    = 2;
  localparam int DEPTH = 8;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] MUL  = 32'h0220_8133;
  localparam logic [31:0] ITAB [16] = '{
    32'h0010_0093, 32'h0010_9093, 32'h4010_d093, 32'h0200_9093,
    32'h0020_81b3, 32'h4020_81b3, 32'h0220_8133, 32'h0220_b133,
    32'h0220_c133, 32'h0000_10b7, 32'h0000_a083, 32'h0010_a023,
    32'h0080_00ef, 32'h0020_8463, 32'h3001_10f3, 32'h1050_0073
  };

  logic       clock = 1'b0;
  logic       reset, flush;
  logic [3:0] count;
  logic       illegal_seen;
  logic [31:0] pc;

  decode_buffer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  decode_buffer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .HALT_ON_ILLEGAL(1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(bus),
    .count(count), .illegal_seen(illegal_seen)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference classification written straight from the ISA class table.
  function automatic int ref_class(input logic [31:0] x);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
    if (x == 32'h1050_0073) return 4;
    case (op)
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? 1 : 0;
        if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? 1 : 0;
        return 1;
      end
      7'h33: begin
        if (f7 == 7'h00) return 1;
        if (f7 == 7'h20) return (f3 == 3'd0 || f3 == 3'd5) ? 1 : 0;
        if (f7 == 7'h01) return (f3 < 3'd4) ? 2 : 0;
        return 0;
      end
      7'h37: return 3;
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? 3 : 0;
      7'h23: return (f3 <= 3'd2) ? 3 : 0;
      7'h17, 7'h6f: return 4;
      7'h67: return (f3 == 3'd0) ? 4 : 0;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? 0 : 4;
      7'h73: return (f3 inside {3'd1, 3'd2, 3'd3}) ? 4 : 0;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          cls;
  } ment_t;

  ment_t       q[$];
  bit          m_ill;
  bit          log_en = 1'b0;
  logic [31:0] deq_log[$];

  // Compare-and-step: check outputs against the queue model, then apply the
  // inputs that the coming rising edge will see.
  always @(negedge clock) begin
    int    nv, a;
    bit    halt, rdy;
    ment_t e;
    if (reset) begin
      q.delete();
      m_ill = 1'b0;
    end else begin
      nv = 0; halt = 1'b0;
      for (int i = 0; i < OW; i++) begin
        if (i < q.size() && !halt) begin
          nv++;
          check("out_valid", bus.out_valid[i], 1'b1);
          check("out_inst", bus.out_inst[i], q[i].inst);
          check("out_pc", bus.out_pc[i], q[i].pc);
          check("out_fu_class", bus.out_fu_class[i], q[i].cls);
          check("out_illegal", bus.out_illegal[i], q[i].cls == 0);
          if (q[i].cls == 0) halt = 1'b1;
        end else begin
          check("out_valid", bus.out_valid[i], 1'b0);
        end
      end
      check("count", count, q.size());
      rdy = (DEPTH - q.size()) >= IW;
      check("in_ready", bus.in_ready, rdy);
      check("illegal_seen", illegal_seen, m_ill);
      if (flush) begin
        q.delete();
      end else begin
        a = (int'(bus.out_accept) < nv) ? int'(bus.out_accept) : nv;
        for (int i = 0; i < a; i++) begin
          if (log_en) deq_log.push_back(bus.out_pc[i]);
          if (q[0].cls == 0) m_ill = 1'b1;
          void'(q.pop_front());
        end
        if (rdy)
          for (int i = 0; i < IW && bus.in_valid[i]; i++) begin
            e.inst = bus.in_inst[i];
            e.pc   = bus.in_pc[i];
            e.cls  = ref_class(bus.in_inst[i]);
            q.push_back(e);
          end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1, input int acc);
    bus.in_valid   = v;
    bus.in_inst[0] = i0;
    bus.in_inst[1] = i1;
    bus.in_pc[0]   = pc;
    bus.in_pc[1]   = pc + 32'd4;
    bus.out_accept = 2'(acc);
    if (v != 2'b00) pc = pc + 32'd8;
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return ITAB[$urandom_range(0, 15)];
  endfunction

  initial begin
    pc = 32'd0;
    reset = 1'b1; flush = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 0);
    cyc(); cyc();
    reset = 1'b0;
    check("rst count", count, 0);
    check("rst out_valid", bus.out_valid, 2'b00);
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst illegal_seen", illegal_seen, 1'b0);

    // ADDI + MUL pair
    pc = 32'd0;
    drive(2'b11, ADDI, MUL, 0); cyc();
    drive(2'b00, 32'd0, 32'd0, 0);
    check("pair out_valid", bus.out_valid, 2'b11);
    check("pair cls0", bus.out_fu_class[0], 3'd1);
    check("pair cls1", bus.out_fu_class[1], 3'd2);
    check("pair pc0", bus.out_pc[0], 32'h0);
    check("pair pc1", bus.out_pc[1], 32'h4);
    check("pair count", count, 2);

    // fill to full, overflow push ignored, then one dequeue reopens
    drive(2'b00, 32'd0, 32'd0, 2); cyc();
    check("drain count", count, 0);
    repeat (4) begin drive(2'b11, ADDI, 32'h0020_81b3, 0); cyc(); end
    check("full count", count, 8);
    check("full in_ready", bus.in_ready, 1'b0);
    drive(2'b11, ADDI, ADDI, 0); cyc();
    check("overflow count", count, 8);
    drive(2'b00, 32'd0, 32'd0, 2); cyc();
    check("deq count", count, 6);
    check("deq in_ready", bus.in_ready, 1'b1);

    // steady-state streaming across several wraps
    repeat (3) begin drive(2'b00, 32'd0, 32'd0, 2); cyc(); end
    pc = 32'd0;
    deq_log.delete();
    repeat (2) begin drive(2'b11, ADDI, ADDI, 0); cyc(); end
    log_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, ADDI, ADDI, 2); cyc();
      check("stream count", count, 4);
    end
    log_en = 1'b0;
    check("stream deq total", deq_log.size(), 40);
    for (int i = 0; i < deq_log.size(); i++) check("stream pc order", deq_log[i], i * 4);
    repeat (2) begin drive(2'b00, 32'd0, 32'd0, 2); cyc(); end
    check("stream drained", count, 0);

    // illegal halts presentation
    drive(2'b11, 32'h0000_0000, ADDI, 0); cyc();
    check("ill out_valid", bus.out_valid, 2'b01);
    check("ill flag", bus.out_illegal[0], 1'b1);
    check("ill cls", bus.out_fu_class[0], 3'd0);
    drive(2'b00, 32'd0, 32'd0, 2); cyc();
    check("ill seen", illegal_seen, 1'b1);
    check("ill next valid", bus.out_valid, 2'b01);
    check("ill next inst", bus.out_inst[0], ADDI);
    check("ill count", count, 1);
    drive(2'b10, ADDI, ADDI, 0); cyc();
    check("gap count", count, 1);
    drive(2'b00, 32'd0, 32'd0, 2); cyc();

    // flush when full, with a competing dequeue
    repeat (4) begin drive(2'b11, ADDI, MUL, 0); cyc(); end
    check("pre-flush count", count, 8);
    flush = 1'b1;
    drive(2'b11, ADDI, ADDI, 2); cyc();
    flush = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 0);
    check("flush count", count, 0);
    check("flush out_valid", bus.out_valid, 2'b00);
    check("flush in_ready", bus.in_ready, 1'b1);
    check("flush illegal_seen", illegal_seen, 1'b1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 29) == 0);
      drive(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 2));
      cyc();
    end
    flush = 1'b0;

    // reset together with flush behaves as reset
    reset = 1'b1; flush = 1'b1;
    drive(2'b11, ADDI, ADDI, 2); cyc();
    reset = 1'b0; flush = 1'b0;
    drive(2'b00, 32'd0, 32'd0, 0);
    check("rf count", count, 0);
    check("rf illegal_seen", illegal_seen, 1'b0);
    check("rf out_valid", bus.out_valid, 2'b00);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
